mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter n, default 32, data and address bus width in bits.
REQ-002 Parameter BASE, default 32'h0000_FF00, word-aligned base address of the 5-register window (BASE..BASE+0x10).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memwrite  input  1  CPU data-bus write strobe; write takes effect at the rising edge while high.
REQ-006 dataadr  input  n  CPU data-bus byte address.
REQ-007 writedata  input  n  CPU store data.
REQ-008 readdata  output  n  load data returned to the CPU, combinational from dataadr and register state.
REQ-009 irq  output  1  interrupt request, level, active-high.

Function
REQ-010 The block SHALL act as the responder side of the CPU data bus, with 0 wait states: reads are combinational and writes complete in the edge at which memwrite is sampled.
REQ-011 Decode SHALL be hit = (dataadr[n-1:5] == BASE[n-1:5]) and word offset dataadr[4:2] in 0..4; dataadr[1:0] are ignored.
REQ-012 Register map: offset 0x00 CTRL, 0x04 COUNT, 0x08 COMPARE, 0x0C STATUS, 0x10 PRESCALE.
REQ-013 CTRL SHALL implement bit0 EN (count enable), bit1 AR (auto-reload on match), bit2 IE (interrupt enable); bits n-1:3 SHALL read 0 and ignore writes.
REQ-014 COUNT and COMPARE SHALL be full n-bit read/write registers.
REQ-015 STATUS SHALL implement bit0 MATCH and bit1 OVF; writing 1 to a bit clears it, writing 0 has no effect; other bits read 0.
REQ-016 PRESCALE SHALL be an 8-bit read/write register in bits 7:0; upper bits read 0.
REQ-017 readdata SHALL be the addressed register when hit, and 0 on a miss or for offsets 5..7.
REQ-018 Writes on a miss, or to offsets 5..7, SHALL change no state.
REQ-019 An internal 8-bit prescale counter SHALL assert a one-cycle tick when it equals PRESCALE with EN=1, then return to 0; otherwise it SHALL increment by 1 while EN=1.
REQ-020 The prescale counter SHALL be held at 0 while EN=0, and SHALL reset to 0 on any write to PRESCALE or CTRL.
REQ-021 The first tick therefore SHALL occur PRESCALE+1 cycles after EN is set; PRESCALE=0 ticks every cycle.
REQ-022 On a tick with COUNT == COMPARE, MATCH SHALL set, and COUNT SHALL load 0 if AR=1 and increment otherwise.
REQ-023 On a tick with COUNT == {n{1'b1}} and no reload, COUNT SHALL wrap to 0 and OVF SHALL set.
REQ-024 On a tick with no match and no wrap, COUNT SHALL increment by 1, modulo 2^n.
REQ-025 A CPU write to COUNT in the same cycle as a tick SHALL take priority: COUNT takes writedata, the tick's increment is discarded, and the match test uses the pre-write COUNT.
REQ-026 A hardware set of MATCH or OVF in the same cycle as a W1C of that bit SHALL leave the bit set.
REQ-027 irq SHALL equal IE & MATCH, combinational from registers, with no additional latency.

Reset
REQ-028 Reset asserted SHALL immediately clear CTRL, COUNT, STATUS, PRESCALE and the prescale counter to 0, set COMPARE to {n{1'b1}}, and force irq=0; readdata then reflects these values.
REQ-029 Reset asserted mid-count SHALL abort counting; no tick, flag set or write SHALL occur at an edge while reset is high.

Verification
REQ-030 After reset: read CTRL/COUNT/COMPARE/STATUS/PRESCALE -> 0, 0, 0xFFFFFFFF, 0, 0; irq=0.
REQ-031 Match with auto-reload: PRESCALE=0, COMPARE=3, CTRL=0x7 -> COUNT reads 1,2,3 on successive cycles; the next tick sets MATCH with COUNT=0 and irq=1; writing STATUS=1 -> irq=0.
REQ-032 Prescale: PRESCALE=4, CTRL=0x1 -> COUNT increments exactly once every 5 cycles; 20 cycles after enable, COUNT=4.
REQ-033 Overflow: COUNT=0xFFFFFFFE, COMPARE=5, PRESCALE=0, CTRL=0x1 -> after 2 ticks COUNT=0, STATUS=0x2, irq=0.
REQ-034 Collisions: (a) write COUNT=0x100 in a tick cycle -> COUNT=0x100; (b) W1C MATCH in the same cycle as a new match -> MATCH remains 1.
REQ-035 Decode: write to BASE+0x14 and to BASE-4 -> no register changes, both read 0; reset pulse mid-count -> all registers return to REQ-028 values without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer: CTRL/COUNT/COMPARE/STATUS/PRESCALE window with
// match, auto-reload, overflow flags and a level interrupt.
module mmio_timer #(
   parameter int           n    = 32,
   parameter logic [n-1:0] BASE = 32'h0000_FF00
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memwrite,
   input  logic [n-1:0] dataadr,
   input  logic [n-1:0] writedata,
   output logic [n-1:0] readdata,
   output logic         irq
);

   logic         r_en, r_ar, r_ie;
   logic [n-1:0] r_count, r_compare;
   logic         r_match, r_ovf;
   logic [7:0]   r_prescale, r_pcnt;

   logic         w_hit;
   logic [2:0]   w_off;
   logic         w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_stat, w_wr_ps;
   logic         w_tick, w_match_set, w_ovf_set;
   logic [n-1:0] w_count_nxt;
   logic [7:0]   w_pcnt_nxt;
   logic         w_match_nxt, w_ovf_nxt;
   logic         w_unused;

   assign w_hit      = (dataadr[n-1:5] == BASE[n-1:5]);
   assign w_off      = dataadr[4:2];
   assign w_unused   = ^dataadr[1:0];
   assign w_wr_ctrl  = memwrite & w_hit & (w_off == 3'd0);
   assign w_wr_count = memwrite & w_hit & (w_off == 3'd1);
   assign w_wr_cmp   = memwrite & w_hit & (w_off == 3'd2);
   assign w_wr_stat  = memwrite & w_hit & (w_off == 3'd3);
   assign w_wr_ps    = memwrite & w_hit & (w_off == 3'd4);

   assign w_tick      = r_en & (r_pcnt == r_prescale);
   assign w_match_set = w_tick & (r_count == r_compare);
   // A reload suppresses the wrap, so OVF only fires when COUNT really rolls over.
   assign w_ovf_set   = w_tick & (r_count == {n{1'b1}}) & ~(w_match_set & r_ar);

   assign irq = r_ie & r_match;

   // Next-state: CPU write to COUNT beats the tick; hardware flag sets beat W1C.
   always_comb begin
      w_count_nxt = r_count;
      w_pcnt_nxt  = r_pcnt + 8'd1;
      w_match_nxt = r_match;
      w_ovf_nxt   = r_ovf;
      if (w_wr_count) begin
         w_count_nxt = writedata;
      end else if (w_match_set & r_ar) begin
         w_count_nxt = {n{1'b0}};
      end else if (w_tick) begin
         w_count_nxt = r_count + {{(n-1){1'b0}}, 1'b1};
      end else begin
         w_count_nxt = r_count;
      end
      if (w_wr_ctrl | w_wr_ps | ~r_en | w_tick) begin
         w_pcnt_nxt = 8'd0;
      end else begin
         w_pcnt_nxt = r_pcnt + 8'd1;
      end
      if (w_wr_stat) begin
         w_match_nxt = r_match & ~writedata[0];
         w_ovf_nxt   = r_ovf & ~writedata[1];
      end else begin
         w_match_nxt = r_match;
         w_ovf_nxt   = r_ovf;
      end
      w_match_nxt = w_match_nxt | w_match_set;
      w_ovf_nxt   = w_ovf_nxt | w_ovf_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en       <= 1'b0;
         r_ar       <= 1'b0;
         r_ie       <= 1'b0;
         r_count    <= {n{1'b0}};
         r_compare  <= {n{1'b1}};
         r_match    <= 1'b0;
         r_ovf      <= 1'b0;
         r_prescale <= 8'd0;
         r_pcnt     <= 8'd0;
      end else begin
         r_count <= w_count_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_match <= w_match_nxt;
         r_ovf   <= w_ovf_nxt;
         if (w_wr_ctrl) begin
            r_en <= writedata[0];
            r_ar <= writedata[1];
            r_ie <= writedata[2];
         end
         if (w_wr_cmp) begin
            r_compare <= writedata;
         end
         if (w_wr_ps) begin
            r_prescale <= writedata[7:0];
         end
      end
   end

   // Zero-wait-state read mux; misses and offsets 5..7 return 0.
   always_comb begin
      readdata = {n{1'b0}};
      if (w_hit) begin
         case (w_off)
            3'd0:    readdata = {{(n-3){1'b0}}, r_ie, r_ar, r_en};
            3'd1:    readdata = r_count;
            3'd2:    readdata = r_compare;
            3'd3:    readdata = {{(n-2){1'b0}}, r_ovf, r_match};
            3'd4:    readdata = {{(n-8){1'b0}}, r_prescale};
            default: readdata = {n{1'b0}};
         endcase
      end else begin
         readdata = {n{1'b0}};
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: vector table, directed corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_mmio_timer;

   localparam logic [31:0] BASE    = 32'h0000_FF00;
   localparam logic [31:0] A_CTRL  = BASE + 32'h00;
   localparam logic [31:0] A_COUNT = BASE + 32'h04;
   localparam logic [31:0] A_CMP   = BASE + 32'h08;
   localparam logic [31:0] A_STAT  = BASE + 32'h0C;
   localparam logic [31:0] A_PS    = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;

   mmio_timer #(.n(32), .BASE(BASE)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp_rd;
      bit          exp_irq;
   } vec_t;

   vec_t tbl[21];

   // reference model state: timer registers plus enabled-cycle phase since restart
   bit [31:0] m_count, m_compare;
   bit [7:0]  m_prescale;
   bit        m_en, m_ar, m_ie, m_match, m_ovf;
   int        m_phase;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      dataadr = a;
      #1;
      chk(nm, readdata, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      #1;
      memwrite = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      memwrite = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic model_reset();
      m_count = 0; m_compare = 32'hFFFF_FFFF; m_prescale = 0;
      m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_ovf = 0; m_phase = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'h0;
      case (int'(a[4:2]))
         0: return {29'h0, m_ie, m_ar, m_en};
         1: return m_count;
         2: return m_compare;
         3: return {30'h0, m_ovf, m_match};
         4: return {24'h0, m_prescale};
         default: return 32'h0;
      endcase
   endfunction

   // one rising edge: ticks land on every (PRESCALE+1)-th enabled edge after a restart
   task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
      bit        hit, tick, mt, ov;
      int        off, k;
      bit [31:0] nc;
      hit  = (a[31:5] == BASE[31:5]);
      off  = int'(a[4:2]);
      k    = m_phase + 1;
      tick = m_en && ((k % (int'(m_prescale) + 1)) == 0);
      mt   = tick && (m_count == m_compare);
      ov   = tick && (m_count == 32'hFFFF_FFFF) && !(mt && m_ar);
      nc   = m_count;
      if (tick) nc = (mt && m_ar) ? 32'h0 : m_count + 32'h1;
      if (we && hit && off == 1) nc = d;
      if (we && hit && (off == 0 || off == 4)) m_phase = 0;
      else if (m_en) m_phase = k;
      else m_phase = 0;
      if (we && hit && off == 3) begin
         if (d[0]) m_match = 0;
         if (d[1]) m_ovf = 0;
      end
      if (mt) m_match = 1;
      if (ov) m_ovf = 1;
      m_count = nc;
      if (we && hit && off == 0) begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
      if (we && hit && off == 2) m_compare = d;
      if (we && hit && off == 4) m_prescale = d[7:0];
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r < 10) return BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
      if (r < 12) return BASE + 32'(4 * $urandom_range(5, 7)) + 32'($urandom_range(0, 3));
      if (r < 14) return BASE - 32'(4 * $urandom_range(1, 4));
      return $urandom;
   endfunction

   function automatic logic [31:0] rand_data(input logic [31:0] a);
      case (int'(a[4:2]))
         1: return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12))
                                               : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         2: return ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
         4: return ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      tbl[0]  = '{0, 32'h0, 32'h0, A_CTRL, 32'h0, 0};
      tbl[1]  = '{0, 32'h0, 32'h0, A_COUNT, 32'h0, 0};
      tbl[2]  = '{0, 32'h0, 32'h0, A_CMP, 32'hFFFF_FFFF, 0};
      tbl[3]  = '{0, 32'h0, 32'h0, A_STAT, 32'h0, 0};
      tbl[4]  = '{0, 32'h0, 32'h0, A_PS, 32'h0, 0};
      tbl[5]  = '{1, A_PS, 32'hFFFF_FF00, A_PS, 32'h0, 0};
      tbl[6]  = '{1, A_CTRL, 32'hFFFF_FFF8, A_CTRL, 32'h0, 0};
      tbl[7]  = '{1, A_CMP, 32'h3, A_CMP, 32'h3, 0};
      tbl[8]  = '{1, BASE + 32'h14, 32'h1234, BASE + 32'h14, 32'h0, 0};
      tbl[9]  = '{1, BASE - 32'h4, 32'h55, BASE - 32'h4, 32'h0, 0};
      tbl[10] = '{0, 32'h0, 32'h0, A_CMP, 32'h3, 0};
      tbl[11] = '{1, A_CTRL, 32'h7, A_COUNT, 32'h0, 0};
      tbl[12] = '{0, 32'h0, 32'h0, A_COUNT, 32'h1, 0};
      tbl[13] = '{0, 32'h0, 32'h0, A_COUNT, 32'h2, 0};
      tbl[14] = '{0, 32'h0, 32'h0, A_COUNT, 32'h3, 0};
      tbl[15] = '{0, 32'h0, 32'h0, A_COUNT, 32'h0, 1};
      tbl[16] = '{0, 32'h0, 32'h0, A_STAT, 32'h1, 1};
      tbl[17] = '{1, A_STAT, 32'h1, A_STAT, 32'h0, 0};
      tbl[18] = '{1, A_CTRL, 32'h0, A_COUNT, 32'h3, 0};
      tbl[19] = '{0, 32'h0, 32'h0, A_COUNT, 32'h3, 0};
      tbl[20] = '{0, 32'h0, 32'h0, BASE + 32'h7, 32'h3, 0};

      reset = 1'b1;
      #12;
      chk("reset_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         memwrite  = tbl[i].we;
         dataadr   = tbl[i].addr;
         writedata = tbl[i].wdata;
         @(posedge clk);
         #1;
         memwrite = 1'b0;
         dataadr  = tbl[i].raddr;
         #1;
         chk($sformatf("vec%0d_rd", i), readdata, tbl[i].exp_rd);
         chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].exp_irq});
      end

      // prescale 4: one count every 5 edges after enable
      do_reset();
      wr(A_PS, 32'h4);
      wr(A_CTRL, 32'h1);
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         rd($sformatf("ps_edge%0d", e), A_COUNT, 32'(e / 5));
      end

      // overflow without reload
      do_reset();
      wr(A_COUNT, 32'hFFFF_FFFE);
      wr(A_CMP, 32'h5);
      wr(A_CTRL, 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rd("ovf_count", A_COUNT, 32'h0);
      rd("ovf_status", A_STAT, 32'h2);
      chk("ovf_irq", {31'h0, irq}, 32'h0);

      // CPU write to COUNT wins over a tick
      do_reset();
      wr(A_CTRL, 32'h1);
      repeat (3) @(posedge clk);
      wr(A_COUNT, 32'h100);
      rd("coll_count_wr", A_COUNT, 32'h100);
      @(posedge clk);
      #1;
      rd("coll_count_next", A_COUNT, 32'h101);

      // W1C of MATCH in a match cycle leaves MATCH set
      do_reset();
      wr(A_CMP, 32'h0);
      wr(A_CTRL, 32'h7);
      @(posedge clk);
      #1;
      rd("coll_match_pre", A_STAT, 32'h1);
      wr(A_STAT, 32'h1);
      rd("coll_w1c_match", A_STAT, 32'h1);
      chk("coll_w1c_irq", {31'h0, irq}, 32'h1);
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h3);
      rd("w1c_clear", A_STAT, 32'h0);
      chk("w1c_clear_irq", {31'h0, irq}, 32'h0);

      // asynchronous reset mid-count, then held across an edge with a write pending
      do_reset();
      wr(A_CMP, 32'h0);
      wr(A_PS, 32'h1);
      wr(A_CTRL, 32'h7);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_irq", {31'h0, irq}, 32'h1);
      reset = 1'b1;
      rd("arst_ctrl", A_CTRL, 32'h0);
      rd("arst_count", A_COUNT, 32'h0);
      rd("arst_cmp", A_CMP, 32'hFFFF_FFFF);
      rd("arst_stat", A_STAT, 32'h0);
      rd("arst_ps", A_PS, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = A_COUNT;
      writedata = 32'h55;
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      rd("rst_hold_count", A_COUNT, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] ra, wa, wd;
         bit          we;
         @(negedge clk);
         memwrite = 1'b0;
         ra = rand_addr();
         rd($sformatf("rnd%0d_rd", c), ra, model_read(ra));
         chk($sformatf("rnd%0d_irq", c), {31'h0, irq}, {31'h0, m_ie & m_match});
         we = ($urandom_range(0, 9) < 3);
         wa = rand_addr();
         wd = rand_data(wa);
         memwrite  = we;
         dataadr   = wa;
         writedata = wd;
         @(posedge clk);
         model_edge(we, wa, wd);
      end
      #1;
      memwrite = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
